// File: rtl/mul_ctrl.sv
// mul_ctrl: EX-stage sequencer for the shared 32x32 multi-cycle multiplier.
// Hands operands to the multiplier, stalls the pipeline until the product returns, then writes back once.
module mul_ctrl #(
    parameter int unsigned TIMEOUT = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    input  logic        flush_i,
    output logic        mul_start_o,
    output logic        mul_annul_o,
    output logic        mul_signed_o,
    output logic [31:0] mul_op1_o,
    output logic [31:0] mul_op2_o,
    input  logic [63:0] mul_result_i,
    input  logic        mul_ready_i,
    output logic        stallreq_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        rd_we_o,
    output logic [31:0] rd_data_o,
    output logic        err_o
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b10;
    localparam logic [1:0] OP_MUL   = 2'b11;

    // Last BUSY cycle allowed before the multiplier is declared hung.
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 32'd1);

    logic [1:0] state_r;
    logic [1:0] op_r;
    logic [7:0] wdog_r;
    logic       issue_s;

    // Issue decode, stall request and writeback strobes; a flush kills all of them in its own cycle.
    always_comb begin
        issue_s    = 1'b0;
        stallreq_o = 1'b0;
        hilo_we_o  = 1'b0;
        rd_we_o    = 1'b0;
        if (state_r == ST_IDLE) begin
            issue_s    = op_valid_i && (op_i != OP_NONE) && !flush_i;
            stallreq_o = issue_s;
        end else if (state_r == ST_BUSY) begin
            stallreq_o = !flush_i;
        end else if (state_r == ST_DONE) begin
            hilo_we_o = !flush_i && (op_r != OP_MUL);
            rd_we_o   = !flush_i && (op_r == OP_MUL);
        end else begin
            stallreq_o = 1'b0;
        end
    end

    // Sequencer state, multiplier handshake, watchdog and captured product.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            op_r         <= 2'b00;
            wdog_r       <= 8'd0;
            mul_start_o  <= 1'b0;
            mul_annul_o  <= 1'b0;
            mul_signed_o <= 1'b0;
            mul_op1_o    <= 32'd0;
            mul_op2_o    <= 32'd0;
            hi_o         <= 32'd0;
            lo_o         <= 32'd0;
            rd_data_o    <= 32'd0;
            err_o        <= 1'b0;
        end else begin
            mul_annul_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        op_r         <= op_i;
                        mul_op1_o    <= src1_i;
                        mul_op2_o    <= src2_i;
                        mul_signed_o <= (op_i != OP_MULTU);
                        mul_start_o  <= 1'b1;
                        wdog_r       <= 8'd0;
                        state_r      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Flush outranks a product arriving in the same cycle.
                    if (flush_i) begin
                        mul_start_o <= 1'b0;
                        mul_annul_o <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else if (mul_ready_i) begin
                        mul_start_o <= 1'b0;
                        if (op_r == OP_MUL) begin
                            rd_data_o <= mul_result_i[31:0];
                        end else begin
                            hi_o <= mul_result_i[63:32];
                            lo_o <= mul_result_i[31:0];
                        end
                        state_r <= ST_DONE;
                    end else if (wdog_r == WDOG_LAST) begin
                        err_o       <= 1'b1;
                        mul_start_o <= 1'b0;
                        mul_annul_o <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        wdog_r <= wdog_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    mul_start_o <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl: stub multiplier, scoreboard of expected writebacks, decoupled monitor.
module tb_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src1 = 32'd0;
    logic [31:0] src2 = 32'd0;
    logic        flush = 1'b0;
    logic        mul_start, mul_annul, mul_signed;
    logic [31:0] mul_op1, mul_op2;
    logic [63:0] mul_result;
    logic        mul_ready;
    logic        stallreq, hilo_we, rd_we, err;
    logic [31:0] hi, lo, rd_data;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        is_rd;
        logic [31:0] hi;
        logic [31:0] lo;
    } wb_t;
    wb_t sb_q[$];

    int lat = 4;
    bit never_ready = 1'b0;
    int mcnt = 0;

    mul_ctrl #(.TIMEOUT(48)) dut (
        .clk(clk), .rst(rst), .op_valid_i(op_valid), .op_i(op),
        .src1_i(src1), .src2_i(src2), .flush_i(flush),
        .mul_start_o(mul_start), .mul_annul_o(mul_annul), .mul_signed_o(mul_signed),
        .mul_op1_o(mul_op1), .mul_op2_o(mul_op2),
        .mul_result_i(mul_result), .mul_ready_i(mul_ready),
        .stallreq_o(stallreq), .hilo_we_o(hilo_we), .hi_o(hi), .lo_o(lo),
        .rd_we_o(rd_we), .rd_data_o(rd_data), .err_o(err)
    );

    always #5 clk = ~clk;

    // Stub multiplier: ready rises lat cycles after start and drops once start is released.
    always @(posedge clk) begin
        if (rst || !mul_start) begin
            mcnt      <= 0;
            mul_ready <= 1'b0;
        end else if (!never_ready) begin
            mcnt <= mcnt + 1;
            if (mcnt >= lat - 1) mul_ready <= 1'b1;
        end
    end

    always_comb begin
        if (mul_signed)
            mul_result = $signed({{32{mul_op1[31]}}, mul_op1}) * $signed({{32{mul_op2[31]}}, mul_op2});
        else
            mul_result = {32'd0, mul_op1} * {32'd0, mul_op2};
    end

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: every writeback strobe must match the oldest expected entry.
    always @(negedge clk) begin
        wb_t e;
        if (!rst && (hilo_we || rd_we)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_wb", 64'({hilo_we, rd_we}), 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("wb_hilo_we", 64'(hilo_we), 64'(!e.is_rd));
                chk("wb_rd_we", 64'(rd_we), 64'(e.is_rd));
                if (e.is_rd) begin
                    chk("wb_rd_data", 64'(rd_data), 64'(e.lo));
                end else begin
                    chk("wb_hi", 64'(hi), 64'(e.hi));
                    chk("wb_lo", 64'(lo), 64'(e.lo));
                end
            end
        end
    end

    // Start must stay low for at least two cycles between operations.
    int gap = 0;
    bit seen_start = 1'b0;
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (mul_start && !prev_start && seen_start)
            chk("start_gap_ge2", 64'(gap >= 2), 64'd1);
        if (mul_start) begin
            seen_start = 1'b1;
            gap = 0;
        end else begin
            gap = gap + 1;
        end
        prev_start = mul_start;
    end

    // Starts at posedge+1, returns at the negedge of the first BUSY cycle.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_sgn, input bit hold);
        op_valid = 1'b1; op = o; src1 = a; src2 = b;
        @(negedge clk);
        chk("stall_issue_cycle", 64'(stallreq), 64'd1);
        @(posedge clk); #1;
        if (!hold) op_valid = 1'b0;
        @(negedge clk);
        chk("start_after_issue", 64'(mul_start), 64'd1);
        chk("signed_sel", 64'(mul_signed), 64'(exp_sgn));
        chk("op1_latched", 64'(mul_op1), 64'(a));
        chk("op2_latched", 64'(mul_op2), 64'(b));
    endtask

    // Waits at negedges until stall drops; returns at that negedge.
    task automatic wait_done(input int limit, output int busy);
        busy = 0;
        while (stallreq && busy < limit) begin
            busy++;
            @(negedge clk);
        end
        chk("wait_bound", 64'(busy < limit), 64'd1);
    endtask

    task automatic step();
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_sgn, input bit hold,
                         input logic [31:0] ehi, input logic [31:0] elo);
        int busy;
        wb_t e;
        e.is_rd = (o == 2'b11); e.hi = ehi; e.lo = elo;
        sb_q.push_back(e);
        issue(o, a, b, exp_sgn, hold);
        wait_done(200, busy);
        chk("no_stall_at_wb", 64'(stallreq), 64'd0);
        step();
    endtask

    initial begin
        int busy;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_start", 64'(mul_start), 64'd0);
        chk("rst_stall", 64'(stallreq), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_hi_lo", {hi, lo}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op(2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
        do_op(2'b11, 32'd7, 32'd6, 1'b1, 1'b1, 32'd0, 32'd42);
        do_op(2'b11, 32'd0, 32'h1234_5678, 1'b1, 1'b1, 32'd0, 32'd0);

        // Flush five cycles into BUSY.
        lat = 20;
        issue(2'b01, 32'd11, 32'd13, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_stall_low", 64'(stallreq), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_annul", 64'(mul_annul), 64'd1);
        chk("flush_start_low", 64'(mul_start), 64'd0);
        chk("flush_idle_stall", 64'(stallreq), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush_annul_1cyc", 64'(mul_annul), 64'd0);
        @(posedge clk); #1;
        lat = 4;
        do_op(2'b10, 32'd3, 32'd5, 1'b0, 1'b0, 32'd0, 32'd15);

        // Hung multiplier: watchdog fires after 48 BUSY cycles.
        never_ready = 1'b1;
        issue(2'b01, 32'h10, 32'h10, 1'b1, 1'b0);
        chk("err_before_timeout", 64'(err), 64'd0);
        wait_done(300, busy);
        chk("timeout_busy_cycles", 64'(busy), 64'd48);
        chk("timeout_err", 64'(err), 64'd1);
        chk("timeout_annul", 64'(mul_annul), 64'd1);
        chk("timeout_start_low", 64'(mul_start), 64'd0);
        step();
        @(negedge clk);
        chk("timeout_annul_1cyc", 64'(mul_annul), 64'd0);
        @(posedge clk); #1;
        never_ready = 1'b0;
        do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h4000_0000, 32'h0000_0000);
        chk("err_sticky", 64'(err), 64'd1);

        // Flush in the same cycle as ready: flush wins, no writeback.
        lat = 6;
        issue(2'b01, 32'd5, 32'd5, 1'b1, 1'b0);
        busy = 0;
        while (!mul_ready && busy < 100) begin
            busy++;
            @(negedge clk);
        end
        chk("ready_seen", 64'(mul_ready), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flushready_annul", 64'(mul_annul), 64'd1);
        chk("flushready_start", 64'(mul_start), 64'd0);
        chk("flushready_no_wb", 64'({hilo_we, rd_we}), 64'd0);
        @(posedge clk); #1;

        // Reset in the middle of BUSY.
        lat = 20;
        issue(2'b01, 32'd9, 32'd9, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_start", 64'(mul_start), 64'd0);
        chk("mrst_annul_signed", 64'({mul_annul, mul_signed}), 64'd0);
        chk("mrst_ops", {mul_op1, mul_op2}, 64'd0);
        chk("mrst_hi_lo", {hi, lo}, 64'd0);
        chk("mrst_rd_data", 64'(rd_data), 64'd0);
        chk("mrst_err", 64'(err), 64'd0);
        chk("mrst_stall_strobes", 64'({stallreq, hilo_we, rd_we}), 64'd0);
        repeat (5) @(negedge clk);
        chk("mrst_no_wb_later", 64'({hilo_we, rd_we}), 64'd0);

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

endmodule
